fp16_chunk_accumulator: RTL and testbench

Downstream stage of the FP16 adder tree. Consumes one tree result (`sum`/`valid_out`) per beat and serially adds NCHUNK consecutive results into one FP16 total, for dot products wider than the tree's N inputs (e.g. state dim 512 = 4 × 128). The tree cannot be stalled, so results land in a small show-ahead FIFO. An FSM drains the FIFO through one `fp16_add_wrapper` instance, whose latency the FSM does not assume.

---
 rtl/fp16_chunk_accumulator.sv | 203 ++++++++++++++++++++
 tb/tb_fp16_chunk_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_chunk_accumulator.sv
// fp16_chunk_accumulator
//   Serially sums NCHUNK consecutive adder-tree results into one FP16 total.
//   Tree results land in a show-ahead FIFO (the tree cannot stall). An FSM
//   (IDLE/ISSUE/WAIT/DONE) drains the FIFO through one fp16_add_wrapper and
//   waits on its valid_out, so the adder latency is not assumed anywhere.
//   Summation order is arrival order: ((p0+p1)+p2)+...
// Ports:
//   clk, rst (async, active-low)
//   in_valid, in_data[DW]   tree result, one per asserted cycle
//   flush                   sync abort: empties FIFO, drops the partial group
//   out_valid               one-cycle pulse, out_sum holds the new total
//   out_sum[DW]             last total, held until the next pulse
//   ovf                     sticky: a result was dropped on a full FIFO
//   grp_cnt[16]             totals since reset/flush
// Build option: CHUNK_ACC_STATUS_EN implements ovf/grp_cnt; otherwise both
//   are tied to 0 and overflow drops data silently.
// Also contains fp16_add_wrapper (fixed-latency FP16 adder, no reset).

module fp16_add_wrapper #(
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] sum
);
  logic [STAGES:1]        vld_pipe;
  logic [STAGES:1][15:0]  res_pipe;
  logic [15:0]            add_res;
  logic [4:0]  ea, eb, ex, ey, d, e;
  logic [10:0] ma, mb, mx, my, m;
  logic        sx, sy, stk, up;
  logic [13:0] mye, mys;
  logic [14:0] s;
  logic [11:0] mr;

  // Align, add/sub, normalise, round-to-nearest-even. Subnormals use
  // exponent 1 without the hidden bit; Inf/NaN/overflow get no special care.
  always_comb begin
    ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma = {|a[14:10], a[9:0]};
    mb = {|b[14:10], b[9:0]};
    if ({ea, ma} >= {eb, mb}) begin
      sx = a[15]; sy = b[15]; ex = ea; ey = eb; mx = ma; my = mb;
    end else begin
      sx = b[15]; sy = a[15]; ex = eb; ey = ea; mx = mb; my = ma;
    end
    d   = ex - ey;
    mye = {my, 3'b000};
    if (d >= 5'd14) begin
      mys = 14'd0;
      stk = |mye;
    end else begin
      mys = mye >> d;
      stk = |(mye & ((14'd1 << d) - 14'd1));
    end
    mys[0] = mys[0] | stk;
    if (sx == sy) s = {1'b0, mx, 3'b000} + {1'b0, mys};
    else          s = {1'b0, mx, 3'b000} - {1'b0, mys};
    e = ex;
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 5'd1;
    end else begin
      for (int i = 0; i < 13; i++)
        if (!s[13] && e > 5'd1) begin
          s = s << 1;
          e = e - 5'd1;
        end
    end
    m  = s[13:3];
    up = s[2] & (s[1] | s[0] | m[0]);
    mr = {1'b0, m} + {11'd0, up};
    if (mr[11]) begin
      mr = {1'b0, mr[11:1]};
      e  = e + 5'd1;
    end
    add_res = {sx, mr[10] ? e : 5'd0, mr[9:0]};
  end

  always_ff @(posedge clk) begin
    vld_pipe[1] <= valid_in;
    res_pipe[1] <= add_res;
    for (int i = 2; i <= STAGES; i++) begin
      vld_pipe[i] <= vld_pipe[i-1];
      res_pipe[i] <= res_pipe[i-1];
    end
  end

  assign valid_out = vld_pipe[STAGES];
  assign sum       = res_pipe[STAGES];
endmodule

module fp16_chunk_accumulator #(
  parameter int DW     = 16,
  parameter int NCHUNK = 4,
  parameter int DEPTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] out_sum,
  output logic          ovf,
  output logic [15:0]   grp_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] NC = 8'(NCHUNK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [DW-1:0] head, acc, add_sum;
  logic [7:0]    cnt;
  logic          add_vin, add_vout;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign pop   = !empty && !flush && (state == IDLE || state == ISSUE);
  // A full FIFO still accepts when the same cycle frees a slot.
  assign push  = in_valid && !flush && (!full || pop);
  assign add_vin = pop && (state == ISSUE);

  fp16_add_wrapper u_add (
    .clk      (clk),
    .valid_in (add_vin),
    .a        (acc),
    .b        (head),
    .valid_out(add_vout),
    .sum      (add_sum)
  );

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          acc   <= head;
          cnt   <= 8'd1;
          state <= (NCHUNK == 1) ? DONE : ISSUE;
        end
        ISSUE: if (!empty) state <= WAIT;
        // Adder results outside WAIT are stale (post flush/reset) and ignored.
        WAIT: if (add_vout) begin
          acc   <= add_sum;
          cnt   <= cnt + 8'd1;
          state <= (cnt + 8'd1 == NC) ? DONE : ISSUE;
        end
        DONE: begin
          out_sum   <= acc;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHUNK_ACC_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= 1'b0;
      grp_cnt <= '0;
    end else if (flush) begin
      grp_cnt <= '0;
    end else begin
      if (in_valid && full && !pop) ovf <= 1'b1;
      if (state == DONE) grp_cnt <= grp_cnt + 16'd1;
    end
  end
`else
  assign ovf     = 1'b0;
  assign grp_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_fp16_chunk_accumulator.sv
// Directed bench for fp16_chunk_accumulator: NCHUNK=4 instance plus an
// NCHUNK=1 instance for the single-chunk latency case.
module tb_fp16_chunk_accumulator;
`ifdef CHUNK_ACC_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 0, rst = 0;
  logic        in_valid = 0, flush = 0, in_valid1 = 0, flush1 = 0;
  logic [15:0] in_data = 0, in_data1 = 0;
  logic        out_valid, ovf, out_valid1, ovf1;
  logic [15:0] out_sum, grp_cnt, out_sum1, grp_cnt1;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] pulses[$];
  int          t1[$];
  logic [15:0] s1[$];
  logic        glitch = 0, dbl = 0, prev_v = 0, vin_seen = 0;
  logic [15:0] prev_sum = 0;

  fp16_chunk_accumulator #(.DW(16), .NCHUNK(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_sum(out_sum), .ovf(ovf), .grp_cnt(grp_cnt));

  fp16_chunk_accumulator #(.DW(16), .NCHUNK(1), .DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .flush(flush1),
    .out_valid(out_valid1), .out_sum(out_sum1), .ovf(ovf1), .grp_cnt(grp_cnt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) pulses.push_back(out_sum);
    if (out_valid && prev_v) dbl = 1;
    if (rst && out_sum !== prev_sum && !out_valid) glitch = 1;
    prev_v   = out_valid;
    prev_sum = out_sum;
    if (out_valid1) begin t1.push_back(cyc); s1.push_back(out_sum1); end
    if (dut1.add_vin) vin_seen = 1;
  end

  task push(input logic [15:0] d);
    in_valid = 1; in_data = d;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (pulses.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0) begin n_bad++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (grp_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_grp_cnt got %0d want 0", grp_cnt); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
  endtask

  task test_basic;
    pulses.delete();
    push(16'h3C00); push(16'h4000); push(16'h4200); push(16'h4400);
    wait_pulses(1, 60);
    n_cmp++; if (pulses.size() != 1) begin n_bad++; $display("FAIL basic_pulses got %0d want 1", pulses.size()); end
    else begin
      n_cmp++; if (pulses[0] !== 16'h4900) begin n_bad++; $display("FAIL basic_sum got %h want 4900", pulses[0]); end
    end
    n_cmp++; if (grp_cnt !== (STAT ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL basic_grp_cnt got %0d want %0d", grp_cnt, STAT ? 1 : 0); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", ovf); end
  endtask

  task test_gaps;
    logic [15:0] v[8];
    int g[8];
    v = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4400, 16'h4400, 16'hC000, 16'h3800};
    g = '{0, 3, 5, 1, 2, 0, 4, 5};
    pulses.delete(); glitch = 0; dbl = 0;
    for (int i = 0; i < 8; i++) begin
      push(v[i]);
      repeat (g[i]) @(posedge clk);
      #1;
    end
    wait_pulses(2, 80);
    n_cmp++; if (pulses.size() != 2) begin n_bad++; $display("FAIL gaps_pulses got %0d want 2", pulses.size()); end
    else begin
      n_cmp++; if (pulses[0] !== 16'h4900) begin n_bad++; $display("FAIL gaps_sum0 got %h want 4900", pulses[0]); end
      n_cmp++; if (pulses[1] !== 16'h4680) begin n_bad++; $display("FAIL gaps_sum1 got %h want 4680", pulses[1]); end
    end
    n_cmp++; if (glitch !== 1'b0) begin n_bad++; $display("FAIL gaps_sum_stable got %b want 0", glitch); end
    n_cmp++; if (dbl !== 1'b0) begin n_bad++; $display("FAIL gaps_single_pulse got %b want 0", dbl); end
    n_cmp++; if (grp_cnt !== (STAT ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL gaps_grp_cnt got %0d want %0d", grp_cnt, STAT ? 3 : 0); end
  endtask

  // 16 pushes of 0.5: 14 are accepted (two drop while the FIFO is full in
  // the second group's first WAIT), so three 2.0 totals and a stuck partial.
  task test_overflow;
    pulses.delete();
    in_valid = 1; in_data = 16'h3800;
    repeat (16) @(posedge clk);
    #1 in_valid = 0;
    wait_pulses(3, 80);
    n_cmp++; if (pulses.size() != 3) begin n_bad++; $display("FAIL ovf_pulses got %0d want 3", pulses.size()); end
    for (int i = 0; i < pulses.size(); i++) begin
      n_cmp++; if (pulses[i] !== 16'h4000) begin n_bad++; $display("FAIL ovf_sum%0d got %h want 4000", i, pulses[i]); end
    end
    n_cmp++; if (ovf !== STAT) begin n_bad++; $display("FAIL ovf_flag got %b want %b", ovf, STAT); end
    n_cmp++; if (grp_cnt !== (STAT ? 16'd6 : 16'd0)) begin n_bad++; $display("FAIL ovf_grp_cnt got %0d want %0d", grp_cnt, STAT ? 6 : 0); end
    flush = 1; @(posedge clk); #1 flush = 0;
    n_cmp++; if (grp_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_grp_cnt got %0d want 0", grp_cnt); end
    n_cmp++; if (ovf !== STAT) begin n_bad++; $display("FAIL flush_keeps_ovf got %b want %b", ovf, STAT); end
    n_cmp++; if (out_sum !== 16'h4000) begin n_bad++; $display("FAIL flush_keeps_sum got %h want 4000", out_sum); end
  endtask

  task test_flush;
    pulses.delete();
    push(16'h4400); push(16'h4400);
    @(posedge clk); #1;
    // FSM now in WAIT with 4+4 in flight; flush also collides with a push.
    flush = 1; in_valid = 1; in_data = 16'h4400;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (pulses.size() != 0) begin n_bad++; $display("FAIL flush_no_pulse got %0d want 0", pulses.size()); end
    push(16'h3C00); push(16'h3C00); push(16'h3C00); push(16'h3C00);
    wait_pulses(1, 60);
    n_cmp++; if (pulses.size() != 1) begin n_bad++; $display("FAIL flush_clean_pulses got %0d want 1", pulses.size()); end
    else begin
      n_cmp++; if (pulses[0] !== 16'h4400) begin n_bad++; $display("FAIL flush_clean_sum got %h want 4400", pulses[0]); end
    end
    n_cmp++; if (grp_cnt !== (STAT ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL flush_clean_grp got %0d want %0d", grp_cnt, STAT ? 1 : 0); end
  endtask

  task test_async_reset;
    pulses.delete();
    push(16'h4000); push(16'h4000);
    #2 rst = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0) begin n_bad++; $display("FAIL arst_out_sum got %h want 0000", out_sum); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL arst_ovf got %b want 0", ovf); end
    n_cmp++; if (grp_cnt !== 16'h0) begin n_bad++; $display("FAIL arst_grp_cnt got %0d want 0", grp_cnt); end
    repeat (5) @(posedge clk);
    #1 rst = 1;
    push(16'h4000); push(16'h4000); push(16'h4000); push(16'h4000);
    wait_pulses(1, 60);
    n_cmp++; if (pulses.size() != 1) begin n_bad++; $display("FAIL arst_pulses got %0d want 1", pulses.size()); end
    else begin
      n_cmp++; if (pulses[0] !== 16'h4800) begin n_bad++; $display("FAIL arst_sum got %h want 4800", pulses[0]); end
    end
    n_cmp++; if (grp_cnt !== (STAT ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL arst_grp got %0d want %0d", grp_cnt, STAT ? 1 : 0); end
  endtask

  task test_nchunk1;
    int t0, k;
    t1.delete(); s1.delete(); vin_seen = 0;
    t0 = cyc;
    in_valid1 = 1; in_data1 = 16'hC000;
    @(posedge clk); #1 in_valid1 = 0;
    k = 0;
    while (t1.size() < 1 && k < 20) begin @(posedge clk); #1; k++; end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (t1.size() != 1) begin n_bad++; $display("FAIL n1_pulses got %0d want 1", t1.size()); end
    else begin
      n_cmp++; if (s1[0] !== 16'hC000) begin n_bad++; $display("FAIL n1_sum got %h want c000", s1[0]); end
      n_cmp++; if (t1[0] - t0 != 3) begin n_bad++; $display("FAIL n1_latency got %0d want 3", t1[0] - t0); end
    end
    n_cmp++; if (vin_seen !== 1'b0) begin n_bad++; $display("FAIL n1_adder_idle got %b want 0", vin_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_flush();
    test_async_reset();
    test_nchunk1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
